// File: rtl/cache_types.sv
// Cache-side types shared by the L2 write buffer and its match logic.
package cache_types;
  typedef logic [127:0] cache_line;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    RESP
  } wb_state_t;

  typedef struct packed {
    logic      valid;
    logic [11:0] tag;
    cache_line data;
  } wb_entry_t;
endpackage

// File: rtl/lc3b_types.sv
// Base LC-3b datapath types.
package lc3b_types;
  typedef logic [15:0] lc3b_word;
endpackage

// File: rtl/wb_match.sv
// Line-address lookup across buffered victims, scanned oldest to newest.
// Combinational; the newest matching entry wins.
module wb_match #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic [DEPTH-1:0] valid,
  input  logic [11:0]      tag [DEPTH],
  input  logic [11:0]      query,
  input  logic [PTR_W-1:0] head,
  output logic             hit,
  output logic [PTR_W-1:0] idx
);

  logic [PTR_W-1:0] pos;

  always_comb begin
    hit = 1'b0;
    idx = head;
    pos = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pos = PTR_W'((int'(head) + k) % DEPTH);
      if (valid[pos] && tag[pos] == query) begin
        hit = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/l2_write_buffer.sv
// Victim write buffer between L2 and memory: mem_resp one cycle after accept, writes stall while full.
// Define L2_WB_FORWARD_EN to serve read hits from the buffer instead of draining first.
module l2_write_buffer
  import lc3b_types::*;
  import cache_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      mem_read,
  input  logic      mem_write,
  input  lc3b_word  mem_address,
  input  cache_line mem_wdata,
  output logic      mem_resp,
  output cache_line mem_rdata,
  output logic      pmem_read,
  output logic      pmem_write,
  output lc3b_word  pmem_address,
  output cache_line pmem_wdata,
  input  cache_line pmem_rdata,
  input  logic      pmem_resp
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  wb_state_t        state;
  wb_state_t        state_nxt;
  logic             settle;

  logic [DEPTH-1:0] ent_valid;
  logic [11:0]      ent_tag [DEPTH];
  logic             hit;
  logic [PTR_W-1:0] hit_idx;
  logic             full;
  logic [11:0]      req_tag;
  logic             unused_offset;

  logic do_alloc;
  logic do_coalesce;
  logic do_fwd;
  logic do_pop;
  logic do_capture;

  assign req_tag       = mem_address[15:4];
  assign unused_offset = ^mem_address[3:0];
  assign full          = (count == CNT_W'(DEPTH));

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = entries[i].valid;
      ent_tag[i]   = entries[i].tag;
    end
  end

  wb_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_match (
    .valid (ent_valid),
    .tag   (ent_tag),
    .query (req_tag),
    .head  (head),
    .hit   (hit),
    .idx   (hit_idx)
  );

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    state_nxt    = state;
    do_alloc     = 1'b0;
    do_coalesce  = 1'b0;
    do_fwd       = 1'b0;
    do_pop       = 1'b0;
    do_capture   = 1'b0;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = entries[head].data;

    case (state)
      IDLE: begin
        // settle: the L2 is still dropping the request it just got a response for
        if (!settle) begin
          if (mem_write) begin
            if (hit) begin
              do_coalesce = 1'b1;
              state_nxt   = RESP;
            end else if (!full) begin
              do_alloc  = 1'b1;
              state_nxt = RESP;
            end else begin
              state_nxt = DRAIN;
            end
          end else if (mem_read) begin
`ifdef L2_WB_FORWARD_EN
            if (hit) begin
              do_fwd    = 1'b1;
              state_nxt = RESP;
            end else begin
              state_nxt = READ;
            end
`else
            state_nxt = hit ? DRAIN : READ;
`endif
          end else if (count != '0) begin
            state_nxt = DRAIN;
          end
        end
      end
      READ: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, 4'h0};
        if (pmem_resp) begin
          do_capture = 1'b1;
          state_nxt  = RESP;
        end
      end
      DRAIN: begin
        pmem_write   = 1'b1;
        pmem_address = {entries[head].tag, 4'h0};
        if (pmem_resp) begin
          do_pop    = 1'b1;
          state_nxt = IDLE;
        end
      end
      RESP: begin
        mem_resp  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      settle    <= 1'b0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      mem_rdata <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].valid <= 1'b0;
      end
    end else begin
      state  <= state_nxt;
      settle <= (state == RESP);

      if (do_alloc) begin
        entries[tail] <= '{valid: 1'b1, tag: req_tag, data: mem_wdata};
        tail          <= ptr_inc(tail);
      end
      if (do_coalesce) begin
        entries[hit_idx].data <= mem_wdata;
      end
      if (do_pop) begin
        entries[head].valid <= 1'b0;
        head                <= ptr_inc(head);
      end
      // a coalesce never changes occupancy, only allocations and pops do
      count <= count + CNT_W'(do_alloc) - CNT_W'(do_pop);

      if (do_fwd) begin
        mem_rdata <= entries[hit_idx].data;
      end
      if (do_capture) begin
        mem_rdata <= pmem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_l2_write_buffer.sv
// Directed bench for l2_write_buffer with a line-level memory/buffer model and a pmem responder.
module tb_l2_write_buffer;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         mem_read, mem_write;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata;
  logic         mem_resp;
  logic [127:0] mem_rdata;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  always #5 clk = ~clk;

  l2_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_resp     (mem_resp),
    .mem_rdata    (mem_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {logic [11:0] tag; logic [127:0] data;} line_t;
  typedef struct {int kind; logic [11:0] tag; logic [127:0] data;} ev_t;
  localparam int EV_DRAIN = 0, EV_PREAD = 1, EV_WRESP = 2, EV_RRESP = 3;

  line_t        q[$];
  ev_t          log_q[$];
  logic [127:0] mem [logic [11:0]];
  bit           hold_resp = 1'b0;

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] default_line(input logic [11:0] tag);
    return {8{4'hA, tag}};
  endfunction

  function automatic logic [127:0] mem_line(input logic [11:0] tag);
    return mem.exists(tag) ? mem[tag] : default_line(tag);
  endfunction

  function automatic int find_q(input logic [11:0] tag);
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].tag == tag) return i;
    return -1;
  endfunction

  // coherent view: newest buffered copy, else memory
  function automatic logic [127:0] view(input logic [11:0] tag);
    int i;
    i = find_q(tag);
    return (i >= 0) ? q[i].data : mem_line(tag);
  endfunction

  function automatic int find_ev(input int kind, input logic [11:0] tag);
    for (int i = 0; i < log_q.size(); i++) if (log_q[i].kind == kind && log_q[i].tag == tag) return i;
    return -1;
  endfunction

  // memory responder: two-cycle latency, frozen while hold_resp is set
  int lat = 0;
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        lat = 0;
      end else if (!(pmem_read || pmem_write)) begin
        lat = 0;
      end else if (!hold_resp) begin
        lat++;
        if (lat >= 2) begin
          if (pmem_read) pmem_rdata = mem_line(pmem_address[15:4]);
          pmem_resp = 1'b1;
        end
      end
    end
  end

  // compare process
  logic         prev_rd = 0, prev_wr = 0, prev_resp = 0, prev_mresp = 0;
  logic [15:0]  prev_addr = '0;
  logic [127:0] prev_wdata = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        q.delete();
        prev_rd = 0; prev_wr = 0; prev_resp = 0; prev_mresp = 0;
        continue;
      end
      chk(!(pmem_read && pmem_write), "pmem_exclusive", {pmem_read, pmem_write}, 0);
      if ((prev_rd || prev_wr) && !prev_resp) begin
        chk(pmem_read == prev_rd && pmem_write == prev_wr && pmem_address == prev_addr,
            "pmem_stable", {pmem_read, pmem_write, pmem_address}, {prev_rd, prev_wr, prev_addr});
        if (prev_wr) chk(pmem_wdata == prev_wdata, "pmem_wdata_stable", pmem_wdata, prev_wdata);
      end
      if (pmem_write && pmem_resp) begin
        chk(q.size() != 0, "drain_from_empty", pmem_address, 0);
        if (q.size() != 0) begin
          chk(pmem_address == {q[0].tag, 4'h0}, "drain_addr", pmem_address, {q[0].tag, 4'h0});
          chk(pmem_wdata == q[0].data, "drain_data", pmem_wdata, q[0].data);
          mem[q[0].tag] = q[0].data;
          log_q.push_back('{EV_DRAIN, pmem_address[15:4], pmem_wdata});
          void'(q.pop_front());
        end
      end
      if (pmem_read && pmem_resp) begin
        chk(find_q(pmem_address[15:4]) < 0, "pread_of_buffered_line", pmem_address, 0);
        chk(pmem_address[3:0] == 4'h0, "pread_offset", pmem_address, {pmem_address[15:4], 4'h0});
        log_q.push_back('{EV_PREAD, pmem_address[15:4], pmem_rdata});
      end
      if (mem_resp) begin
        chk(!prev_mresp, "resp_pulse", 2, 1);
        chk(mem_read || mem_write, "resp_without_req", 1, 0);
        if (mem_write) begin
          int i;
          i = find_q(mem_address[15:4]);
          if (i >= 0) q[i].data = mem_wdata;
          else q.push_back('{mem_address[15:4], mem_wdata});
          chk(q.size() <= DEPTH, "occupancy_bound", q.size(), DEPTH);
          log_q.push_back('{EV_WRESP, mem_address[15:4], mem_wdata});
        end else if (mem_read) begin
          chk(mem_rdata == view(mem_address[15:4]), "read_data", mem_rdata, view(mem_address[15:4]));
          log_q.push_back('{EV_RRESP, mem_address[15:4], mem_rdata});
        end
      end
      prev_rd    = pmem_read;
      prev_wr    = pmem_write;
      prev_resp  = pmem_resp;
      prev_addr  = pmem_address;
      prev_wdata = pmem_wdata;
      prev_mresp = mem_resp;
    end
  end

  // L2-side driver; every task starts and ends at posedge+1
  task automatic start_req(input bit wr, input logic [15:0] addr, input logic [127:0] data);
    mem_write   = wr;
    mem_read    = !wr;
    mem_address = addr;
    mem_wdata   = data;
  endtask

  task automatic wait_resp(input int budget, output int n, output bit saw_pread, output logic [127:0] rdata);
    n = 0;
    saw_pread = 0;
    rdata = '0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      saw_pread |= pmem_read;
      if (mem_resp) break;
    end
    rdata = mem_rdata;
    chk(mem_resp, "resp_timeout", n, budget);
  endtask

  task automatic end_req();
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic quiesce();
    int n;
    hold_resp = 1'b0;
    n = 0;
    while (n < 200 && (q.size() != 0 || pmem_write || pmem_read)) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(n < 200, "quiesce_timeout", n, 200);
    repeat (2) @(posedge clk);
    #1;
  endtask

  int           n;
  bit           sp;
  logic [127:0] rd;
  logic [127:0] da, db;

  initial begin
    reset_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk(mem_resp == 1'b0, "reset_mem_resp", mem_resp, 0);
    chk(pmem_read == 1'b0 && pmem_write == 1'b0, "reset_pmem", {pmem_read, pmem_write}, 0);
    chk(mem_rdata == '0, "reset_rdata", mem_rdata, 0);
    chk(dut.count == 0, "reset_count", dut.count, 0);

    // write 0x1230, then its drain
    da = {4{32'h1230_0001}};
    start_req(1, 16'h1230, da);
    wait_resp(20, n, sp, rd);
    chk(n == 2, "w1230_latency", n, 2);
    end_req();
    chk(pmem_write == 1'b0 && pmem_read == 1'b0, "w1230_pmem_idle", {pmem_read, pmem_write}, 0);
    quiesce();
    chk(log_q.size() == 2 && log_q[0].kind == EV_WRESP, "w1230_order", log_q.size(), 2);
    chk(find_ev(EV_DRAIN, 12'h123) == 1, "w1230_drained", find_ev(EV_DRAIN, 12'h123), 1);
    chk(mem_line(12'h123) == 128'h12300001123000011230000112300001, "w1230_drain_data", mem_line(12'h123), da);
    log_q.delete();

    // full buffer stalls a third write until the first drain completes
    hold_resp = 1'b1;
    start_req(1, 16'h0100, {4{32'h0100_0100}});
    wait_resp(20, n, sp, rd);
    end_req();
    start_req(1, 16'h0200, {4{32'h0200_0200}});
    wait_resp(20, n, sp, rd);
    end_req();
    chk(dut.count == 2, "full_count", dut.count, 2);
    start_req(1, 16'h0300, {4{32'h0300_0300}});
    repeat (10) begin
      @(negedge clk);
      chk(!mem_resp, "stall_resp_low", mem_resp, 0);
    end
    chk(pmem_write && pmem_address == 16'h0100, "stall_drain_head", pmem_address, 16'h0100);
    hold_resp = 1'b0;
    wait_resp(30, n, sp, rd);
    end_req();
    chk(find_ev(EV_DRAIN, 12'h010) >= 0 && find_ev(EV_DRAIN, 12'h010) < find_ev(EV_WRESP, 12'h030),
        "stall_order", find_ev(EV_WRESP, 12'h030), find_ev(EV_DRAIN, 12'h010));
    quiesce();
    log_q.delete();

    // read of a buffered line
    da = {4{32'h4440_BEEF}};
    start_req(1, 16'h4440, da);
    wait_resp(20, n, sp, rd);
    end_req();
    start_req(0, 16'h4448, '0);
    wait_resp(40, n, sp, rd);
    end_req();
    chk(rd == 128'h4440BEEF4440BEEF4440BEEF4440BEEF, "fwd_rdata", rd, da);
`ifdef L2_WB_FORWARD_EN
    chk(!sp, "fwd_no_pread", sp, 0);
`else
    chk(find_ev(EV_DRAIN, 12'h444) >= 0 && find_ev(EV_DRAIN, 12'h444) < find_ev(EV_PREAD, 12'h444),
        "nofwd_drain_first", find_ev(EV_PREAD, 12'h444), find_ev(EV_DRAIN, 12'h444));
`endif
    quiesce();
    log_q.delete();

    // coalesce two writes to 0x0800
    da = {4{32'hAAAA_0800}};
    db = {4{32'hBBBB_0800}};
    start_req(1, 16'h0800, da);
    wait_resp(20, n, sp, rd);
    end_req();
    start_req(1, 16'h0800, db);
    wait_resp(20, n, sp, rd);
    end_req();
    chk(dut.count == 1, "coalesce_count", dut.count, 1);
    quiesce();
    chk(find_ev(EV_DRAIN, 12'h080) >= 0 && log_q[find_ev(EV_DRAIN, 12'h080)].data == 128'hBBBB0800BBBB0800BBBB0800BBBB0800,
        "coalesce_data", mem_line(12'h080), db);
    chk(log_q.size() == 3, "coalesce_single_drain", log_q.size(), 3);
    log_q.delete();

    // read miss takes priority over a pending drain
    start_req(1, 16'h0900, {4{32'h0900_0900}});
    wait_resp(20, n, sp, rd);
    end_req();
    start_req(0, 16'h2000, '0);
    wait_resp(40, n, sp, rd);
    end_req();
    chk(rd == {8{16'hA200}}, "miss_rdata", rd, {8{16'hA200}});
    quiesce();
    chk(find_ev(EV_PREAD, 12'h200) >= 0 && find_ev(EV_PREAD, 12'h200) < find_ev(EV_DRAIN, 12'h090),
        "miss_before_drain", find_ev(EV_PREAD, 12'h200), find_ev(EV_DRAIN, 12'h090));
    log_q.delete();

    // reset in the middle of a drain
    hold_resp = 1'b1;
    start_req(1, 16'h5550, {4{32'h5550_5550}});
    wait_resp(20, n, sp, rd);
    end_req();
    n = 0;
    while (n < 10 && !pmem_write) begin
      @(negedge clk);
      n++;
    end
    chk(pmem_write, "rst_drain_started", pmem_write, 1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk(pmem_write == 1'b0, "rst_pmem_write_drop", pmem_write, 0);
    chk(dut.count == 0, "rst_count", dut.count, 0);
    reset_n = 1'b1;
    hold_resp = 1'b0;
    start_req(0, 16'h5550, '0);
    wait_resp(40, n, sp, rd);
    end_req();
    chk(sp && find_ev(EV_PREAD, 12'h555) >= 0, "rst_read_to_pmem", sp, 1);
    chk(rd == {8{16'hA555}}, "rst_lost_line", rd, {8{16'hA555}});

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
